// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among numClients requesters.
// Reads return through per-client 2-entry buffers; credits keep the BRAM free of backpressure.
`timescale 1ns/1ps

module bram_port_arbiter_rbuf #(
   parameter int W = 36
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         i_req_valid,
   input  logic         i_req_write,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_deq,
   output logic         o_elig,
   output logic         o_valid,
   output logic [W-1:0] o_head
);
   logic [1:0]   r_occ;
   logic [W-1:0] r_e0, r_e1;
   logic         w_pop;
   logic [2:0]   w_used;

   assign w_pop   = i_deq & (r_occ != 2'd0);
   // i_push doubles as the in-flight hit: a read issued last cycle lands here next edge
   assign w_used  = {1'b0, r_occ} + {2'b0, i_push};
   assign o_elig  = i_req_valid & (i_req_write | (w_used < 3'd2));
   assign o_valid = (r_occ != 2'd0);
   assign o_head  = r_e0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_occ <= 2'd0;
         r_e0  <= '0;
         r_e1  <= '0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_e0 <= i_push_data;
               else               r_e1 <= i_push_data;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_e0  <= r_e1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_e0 <= i_push_data;
               end else begin
                  r_e0 <= r_e1;
                  r_e1 <= i_push_data;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

module bram_port_arbiter #(
   parameter int dataWidth  = 36,
   parameter int addrWidth  = 9,
   parameter int numClients = 4
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [numClients-1:0]            req_valid,
   input  logic [numClients-1:0]            req_write,
   input  logic [numClients*addrWidth-1:0]  req_addr,
   input  logic [numClients*dataWidth-1:0]  req_data,
   output logic [numClients-1:0]            req_grant,
   output logic [numClients-1:0]            resp_valid,
   output logic [numClients*dataWidth-1:0]  resp_data,
   input  logic [numClients-1:0]            resp_deq,
   output logic                             bram_en,
   output logic                             bram_we,
   output logic [addrWidth-1:0]             bram_addr,
   output logic [dataWidth-1:0]             bram_di,
   input  logic [dataWidth-1:0]             bram_do
);
   localparam int IW = $clog2(numClients);

   logic [IW-1:0]         r_last;
   logic                  r_inflight_v;
   logic [IW-1:0]         r_inflight_id;
   logic [numClients-1:0] w_elig;
   logic [numClients-1:0] w_push;
   logic [IW-1:0]         w_win;
   logic                  w_any;

   genvar gi;
   generate
      for (gi = 0; gi < numClients; gi++) begin : g_client
         assign w_push[gi] = r_inflight_v & (r_inflight_id == IW'(gi));
         bram_port_arbiter_rbuf #(.W(dataWidth)) u_rbuf (
            .CLK         (CLK),
            .RST         (RST),
            .i_req_valid (req_valid[gi]),
            .i_req_write (req_write[gi]),
            .i_push      (w_push[gi]),
            .i_push_data (bram_do),
            .i_deq       (resp_deq[gi]),
            .o_elig      (w_elig[gi]),
            .o_valid     (resp_valid[gi]),
            .o_head      (resp_data[gi*dataWidth +: dataWidth])
         );
      end
   endgenerate

   // Search starts one past the last winner, wrapping, so every eligible client is reached in numClients cycles
   always_comb begin
      int idx;
      w_any     = 1'b0;
      w_win     = '0;
      req_grant = '0;
      for (int k = 1; k <= numClients; k++) begin
         idx = int'(r_last) + k;
         if (idx >= numClients) idx = idx - numClients;
         if (!w_any && w_elig[idx]) begin
            w_any = 1'b1;
            w_win = IW'(idx);
         end
      end
      if (RST) w_any = 1'b0;
      if (w_any) req_grant[w_win] = 1'b1;
   end

   assign bram_en   = w_any;
   assign bram_we   = w_any & req_write[w_win];
   assign bram_addr = w_any ? req_addr[w_win*addrWidth +: addrWidth] : '0;
   assign bram_di   = w_any ? req_data[w_win*dataWidth +: dataWidth] : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_last        <= IW'(numClients - 1);
         r_inflight_v  <= 1'b0;
         r_inflight_id <= '0;
      end else begin
         if (w_any) r_last <= w_win;
         r_inflight_v  <= w_any & ~req_write[w_win];
         r_inflight_id <= w_win;
      end
   end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of a dual-ported BRAM among numClients requesters using round-robin arbitration.
- Issues at most one BRAM access per cycle.
- Steers each read result back to the client that issued it, through a per-client 2-entry response buffer.
- Credit-based flow control: a read is granted only when its response is guaranteed buffer space, so the BRAM never needs backpressure.

Parameters:
- dataWidth, 36, BRAM word width.
- addrWidth, 9, BRAM address width.
- numClients, 4, number of requesters; legal range 2..8.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  numClients  per-client request pending.
- req_write  in  numClients  1 = write, 0 = read.
- req_addr  in  numClients*addrWidth  packed addresses; client i at bits [i*addrWidth +: addrWidth].
- req_data  in  numClients*dataWidth  packed write data.
- req_grant  out  numClients  one-hot (or zero); combinational accept of the request this cycle.
- resp_valid  out  numClients  head of client i's response buffer is valid.
- resp_data  out  numClients*dataWidth  packed buffer heads.
- resp_deq  in  numClients  pop client i's buffer head.
- bram_en  out  1  port enable.
- bram_we  out  1  port write enable.
- bram_addr  out  addrWidth  port address.
- bram_di  out  dataWidth  port write data.
- bram_do  in  dataWidth  port read data; valid the cycle after a registered read.

Behaviour:
- Eligibility, client i: req_valid[i] & (req_write[i] | credit[i] > 0).
- credit[i] = 2 - occ[i] - inflight_hit[i]. Computed from registered state only.
  - occ[i]: current buffer occupancy.
  - inflight_hit[i]: 1 if a read for client i was issued last cycle.
- Arbitration:
  - Round-robin pointer last holds the last granted index.
  - Search order: last+1, last+2, …, wrapping modulo numClients.
  - First eligible client gets req_grant; last updates to it on the clock edge.
  - No grant → last unchanged.
- Reset value of last = numClients-1, so client 0 wins first.
- BRAM drive (combinational from the winner):
  - bram_en = |req_grant; bram_we = winner's req_write.
  - bram_addr / bram_di = winner's fields.
  - All BRAM outputs are 0 when no grant.
- Client protocol:
  - Holds request fields stable while req_valid is high and ungranted.
  - A grant consumes the request that cycle.
- Read pipeline:
  - Cycle t: grant read → inflight_v <= 1, inflight_id <= winner.
  - Cycle t+1: bram_do pushed into buffer[inflight_id] at the edge ending t+1.
  - Cycle t+2: resp_valid[id] = 1.
  - Fixed read-to-response latency = 2 cycles.
- Writes: no response, no credit consumed; completed in BRAM at the edge ending the grant cycle.
- Ordering:
  - A read granted in any cycle after a write to the same address returns the new data.
  - Back-to-back reads from one client return in issue order.
- Response buffer (per client, 2-entry FIFO):
  - resp_data shows the head.
  - resp_deq with resp_valid low is ignored.
  - Simultaneous push and pop at occ=1: occ stays 1, new head correct.
  - Push and pop at occ=2 cannot overflow; a pop frees credit only from the next cycle.
- Starvation: a client that holds req_valid and stays eligible is granted within numClients cycles.
- Reset (RST high at an edge):
  - Clears all buffers (occ=0), inflight_v=0, last=numClients-1.
  - An in-flight read is discarded; its data is never delivered.
  - req_grant and bram_en are forced 0 while RST is high.
  - Reset values: resp_valid=0, req_grant=0, bram_en=0, bram_we=0, bram_addr=0, bram_di=0.

Test Plan:
- Client 0 writes 36'h123456789 @ addr 5 (cycle 1), reads addr 5 (cycle 2) → resp_valid[0] in cycle 4, resp_data = 36'h123456789.
- All 4 clients hold reads to addrs 0..3 from the cycle after reset:
  - grants in order 0,1,2,3, one per cycle, each on cycle 0..3;
  - resp_valid[i] rises 2 cycles after its grant.
- Client 1 issues 3 reads and never asserts resp_deq:
  - first two granted, third held ungranted;
  - one resp_deq pulse → third granted the cycle after the pop.
- Client 2 with a full buffer issues a write → granted immediately (no credit needed), data present in BRAM on a later read.
- Contention fairness: clients 0 and 3 request continuously, clients 1 and 2 idle → grants alternate 0,3,0,3.
- Client 0 read granted at cycle t, RST asserted during cycle t+1 → no resp_valid ever appears for that read; all outputs 0 after reset; the first post-reset grant goes to the lowest requesting index.
